// File: rtl/memory_access_stage_pkg.sv
// Shared constants for the memory access stage: funct3 codes, opcodes and FSM encoding.
package memory_access_stage_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   function automatic logic is_mem_opcode(input logic [6:0] opcode);
      return (opcode == OP_LOAD) || (opcode == OP_STORE);
   endfunction

endpackage

// File: rtl/memory_access_stage_align.sv
// Combinational byte-lane logic: store strobes/data replication, misalignment
// detection and load byte/halfword selection with sign or zero extension.
module load_store_align
   import memory_access_stage_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic        is_store,
   input  logic [31:0] store_data,
   input  logic [31:0] load_word,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   output logic        misaligned,
   output logic [31:0] load_data
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   assign sel_byte = load_word[{offset, 3'b000} +: 8];
   assign sel_half = load_word[{offset[1], 4'b0000} +: 16];

   always_comb begin
      wstrb      = 4'b1111;
      wdata      = store_data;
      misaligned = 1'b0;
      load_data  = load_word;
      if (is_store) begin
         case (funct3)
            F3_SB: begin
               wstrb = 4'b0001 << offset;
               wdata = {4{store_data[7:0]}};
            end
            F3_SH: begin
               wstrb      = 4'b0011 << offset;
               wdata      = {2{store_data[15:0]}};
               misaligned = offset[0];
            end
            F3_SW:   misaligned = |offset;
            default: misaligned = |offset;
         endcase
      end else begin
         // Unrecognised load widths fall back to a full-word load.
         case (funct3)
            F3_LB:  load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_LBU: load_data = {24'h0, sel_byte};
            F3_LH: begin
               load_data  = {{16{sel_half[15]}}, sel_half};
               misaligned = offset[0];
            end
            F3_LHU: begin
               load_data  = {16'h0, sel_half};
               misaligned = offset[0];
            end
            F3_LW:   misaligned = |offset;
            default: misaligned = |offset;
         endcase
      end
   end

endmodule

// File: rtl/memory_access_stage.sv
// MEM stage: one instruction per handshake, RV32I loads/stores over a
// ready-handshaked single-port data memory, registered MEM/WB bundle out.
module memory_access_stage
   import memory_access_stage_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int XLEN   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [31:0]       ex_instruction,
   input  logic [XLEN-1:0]   ex_alu_result,
   input  logic [XLEN-1:0]   ex_rs2_data,
   input  logic              ex_reg_write_enable,
   input  logic              ex_mem_read,
   input  logic              ex_mem_write,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [XLEN-1:0]   dmem_wdata,
   output logic [3:0]        dmem_wstrb,
   input  logic [XLEN-1:0]   dmem_rdata,
   input  logic              dmem_ready,
   output logic              wb_valid,
   output logic [31:0]       wb_instruction,
   output logic [XLEN-1:0]   wb_result,
   output logic              wb_reg_write_enable,
   output logic              wb_misaligned
);

   logic [1:0]      state;
   logic [31:0]     held_instr;
   logic [XLEN-1:0] held_alu;
   logic [2:0]      held_f3;
   logic [1:0]      held_off;
   logic            held_load;
   logic            held_rwe;

   logic [2:0]      f3_sel;
   logic [1:0]      off_sel;
   logic            store_sel;
   logic [3:0]      strb_c;
   logic [31:0]     wdata_c;
   logic            mis_c;
   logic [31:0]     load_c;
   logic            mem_op;
   logic            rd_nz;

   assign ex_ready = (state == ST_IDLE);
   assign mem_op   = ex_mem_read | ex_mem_write;
   assign rd_nz    = |ex_instruction[11:7];

   // In IDLE the aligner looks at the incoming instruction; while an access is
   // outstanding it formats the returning word using the captured funct3/offset.
   assign f3_sel    = ex_ready ? ex_instruction[14:12] : held_f3;
   assign off_sel   = ex_ready ? ex_alu_result[1:0]    : held_off;
   assign store_sel = ex_ready ? ex_mem_write          : ~held_load;

   load_store_align u_align (
      .funct3     (f3_sel),
      .offset     (off_sel),
      .is_store   (store_sel),
      .store_data (ex_rs2_data),
      .load_word  (dmem_rdata),
      .wstrb      (strb_c),
      .wdata      (wdata_c),
      .misaligned (mis_c),
      .load_data  (load_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state               <= ST_IDLE;
         dmem_req            <= 1'b0;
         dmem_we             <= 1'b0;
         dmem_addr           <= '0;
         dmem_wdata          <= '0;
         dmem_wstrb          <= 4'b0000;
         wb_valid            <= 1'b0;
         wb_instruction      <= '0;
         wb_result           <= '0;
         wb_reg_write_enable <= 1'b0;
         wb_misaligned       <= 1'b0;
         held_instr          <= '0;
         held_alu            <= '0;
         held_f3             <= '0;
         held_off            <= '0;
         held_load           <= 1'b0;
         held_rwe            <= 1'b0;
      end else begin
         wb_valid      <= 1'b0;
         wb_misaligned <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (ex_valid) begin
                  if (mem_op && !mis_c) begin
                     state      <= ST_ACCESS;
                     dmem_req   <= 1'b1;
                     dmem_we    <= ex_mem_write;
                     dmem_addr  <= {ex_alu_result[ADDR_W-1:2], 2'b00};
                     dmem_wstrb <= ex_mem_write ? strb_c : 4'b0000;
                     dmem_wdata <= wdata_c;
                     held_instr <= ex_instruction;
                     held_alu   <= ex_alu_result;
                     held_f3    <= ex_instruction[14:12];
                     held_off   <= ex_alu_result[1:0];
                     held_load  <= ex_mem_read;
                     held_rwe   <= ex_reg_write_enable & rd_nz & ~ex_mem_write;
                  end else begin
                     wb_valid            <= 1'b1;
                     wb_instruction      <= ex_instruction;
                     wb_result           <= ex_alu_result;
                     wb_reg_write_enable <= ex_reg_write_enable & rd_nz & ~ex_mem_write
                                            & ~(mem_op & mis_c);
                     wb_misaligned       <= mem_op & mis_c;
                  end
               end
            end
            ST_ACCESS: begin
               if (dmem_ready) begin
                  state               <= ST_RESP;
                  dmem_req            <= 1'b0;
                  dmem_we             <= 1'b0;
                  wb_valid            <= 1'b1;
                  wb_instruction      <= held_instr;
                  wb_result           <= held_load ? load_c : held_alu;
                  wb_reg_write_enable <= held_rwe;
               end
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: directed scenarios plus random
// traffic against a byte-lane arithmetic model of RV32I load/store behaviour.
module tb_memory_access_stage;
   import memory_access_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ex_valid = 1'b0;
   logic        ex_ready;
   logic [31:0] ex_instruction = '0;
   logic [31:0] ex_alu_result = '0;
   logic [31:0] ex_rs2_data = '0;
   logic        ex_reg_write_enable = 1'b0;
   logic        ex_mem_read = 1'b0;
   logic        ex_mem_write = 1'b0;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic [31:0] dmem_rdata = '0;
   logic        dmem_ready = 1'b0;
   logic        wb_valid;
   logic [31:0] wb_instruction;
   logic [31:0] wb_result;
   logic        wb_reg_write_enable;
   logic        wb_misaligned;

   int total = 0;
   int bad   = 0;

   localparam logic [6:0] OP_ALU = 7'b0110011;

   memory_access_stage #(.ADDR_W(32), .XLEN(32)) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_instruction(ex_instruction), .ex_alu_result(ex_alu_result),
      .ex_rs2_data(ex_rs2_data), .ex_reg_write_enable(ex_reg_write_enable),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
      .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
      .wb_valid(wb_valid), .wb_instruction(wb_instruction), .wb_result(wb_result),
      .wb_reg_write_enable(wb_reg_write_enable), .wb_misaligned(wb_misaligned)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        timeout;
      logic        saw_req;
      logic        unstable;
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] instr;
      logic [31:0] result;
      logic        rwe;
      logic        mis;
      logic [7:0]  latency;
      logic        ready_at_wb;
      logic        valid_after;
   } obs_t;

   // ---------------- reference model ----------------
   function automatic int acc_bytes(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] w);
      logic [31:0] sh;
      logic [31:0] v;
      int n;
      n  = acc_bytes(f3);
      sh = w >> (8 * int'(off));
      if (n == 1) begin
         v = sh & 32'hFF;
         if (!f3[2] && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end else if (n == 2) begin
         v = sh & 32'hFFFF;
         if (!f3[2] && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [1:0] off);
      int n;
      int m;
      n = acc_bytes(f3);
      m = ((1 << n) - 1) << int'(off);
      return m[3:0];
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] rs2);
      logic [31:0] r;
      int n;
      n = acc_bytes(f3);
      r = '0;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = rs2[8*(i % n) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] mk_instr(input logic [6:0] op, input logic [4:0] rd,
                                            input logic [2:0] f3);
      logic [16:0] hi;
      hi = 17'($urandom);
      return {hi, f3, rd, op};
   endfunction

   // ---------------- driver (collects observations, does not judge) ----------------
   task automatic run_op(input logic [31:0] instr, input logic [31:0] alu, input logic [31:0] rs2,
                         input logic rwe, input logic mr, input logic mw,
                         input logic [31:0] rdata, input int waits, output obs_t o);
      int cyc;
      int reqc;
      logic done;
      o = '0;
      @(negedge clk);
      ex_valid = 1'b1; ex_instruction = instr; ex_alu_result = alu; ex_rs2_data = rs2;
      ex_reg_write_enable = rwe; ex_mem_read = mr; ex_mem_write = mw; dmem_ready = 1'b0;
      @(negedge clk);
      ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
      cyc = 1; reqc = 0; done = 1'b0;
      while (!done && cyc <= 40) begin
         if (wb_valid) begin
            o.instr = wb_instruction; o.result = wb_result; o.rwe = wb_reg_write_enable;
            o.mis = wb_misaligned; o.latency = 8'(cyc); o.ready_at_wb = ex_ready;
            dmem_ready = 1'b0;
            done = 1'b1;
         end else if (dmem_req) begin
            if (!o.saw_req) begin
               o.saw_req = 1'b1; o.addr = dmem_addr; o.we = dmem_we;
               o.wdata = dmem_wdata; o.wstrb = dmem_wstrb;
            end else if (dmem_addr !== o.addr || dmem_we !== o.we ||
                         dmem_wdata !== o.wdata || dmem_wstrb !== o.wstrb) begin
               o.unstable = 1'b1;
            end
            if (reqc == waits) begin
               dmem_ready = 1'b1; dmem_rdata = rdata;
            end else begin
               dmem_ready = 1'b0; dmem_rdata = $urandom;
            end
            reqc++;
         end else begin
            dmem_ready = 1'b0;
         end
         if (!done) begin
            @(negedge clk);
            cyc++;
         end
      end
      if (!done) o.timeout = 1'b1;
      dmem_ready = 1'b0;
      @(negedge clk);
      o.valid_after = wb_valid;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      ex_valid = 1'b1; ex_mem_read = 1'b1; ex_alu_result = 32'h0000_5000;
      repeat (2) @(negedge clk);
      total++;
      if ({wb_valid, wb_reg_write_enable, wb_misaligned, dmem_req, dmem_we} !== 5'b0 ||
          wb_instruction !== 32'h0 || wb_result !== 32'h0 || dmem_addr !== 32'h0 ||
          dmem_wdata !== 32'h0 || dmem_wstrb !== 4'b0000 || ex_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_state got valid=%b req=%b we=%b addr=%h wdata=%h strb=%b res=%h ready=%b want all zero, ready=1",
                  wb_valid, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, wb_result, ex_ready);
      end
      ex_valid = 1'b0; ex_mem_read = 1'b0; ex_alu_result = '0;
      rst = 1'b0;
   endtask

   task automatic test_alu();
      obs_t o;
      run_op(mk_instr(OP_ALU, 5'd5, 3'b000), 32'h0000_00AA, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 0, o);
      total++;
      if (o.timeout || o.latency !== 8'd1 || o.result !== 32'h0000_00AA || o.rwe !== 1'b1 ||
          o.saw_req || o.ready_at_wb !== 1'b1 || o.valid_after !== 1'b0) begin
         bad++;
         $display("FAIL alu_basic got lat=%0d res=%h rwe=%b req=%b ready=%b after=%b want lat=1 res=000000aa rwe=1 req=0 ready=1 after=0",
                  o.latency, o.result, o.rwe, o.saw_req, o.ready_at_wb, o.valid_after);
      end
   endtask

   task automatic test_store_sb();
      obs_t o;
      run_op(mk_instr(OP_STORE, 5'd9, F3_SB), 32'h0000_1003, 32'h1234_5678, 1'b1, 1'b0, 1'b1,
             32'h0, 1, o);
      total++;
      if (o.timeout || !o.saw_req || o.addr !== 32'h1000 || o.wstrb !== 4'b1000 ||
          o.wdata !== 32'h7878_7878 || o.we !== 1'b1 || o.rwe !== 1'b0) begin
         bad++;
         $display("FAIL store_sb got addr=%h strb=%b wdata=%h we=%b rwe=%b want addr=00001000 strb=1000 wdata=78787878 we=1 rwe=0",
                  o.addr, o.wstrb, o.wdata, o.we, o.rwe);
      end
   endtask

   task automatic test_load_wait();
      obs_t o;
      run_op(mk_instr(OP_LOAD, 5'd7, F3_LB), 32'h0000_2001, 32'h0, 1'b1, 1'b1, 1'b0,
             32'h0000_8000, 3, o);
      total++;
      if (o.timeout || o.unstable || o.addr !== 32'h2000 || o.wstrb !== 4'b0000 ||
          o.we !== 1'b0 || o.result !== 32'hFFFF_FF80 || o.latency !== 8'd5 ||
          o.ready_at_wb !== 1'b0 || o.rwe !== 1'b1) begin
         bad++;
         $display("FAIL load_lb_wait got res=%h unstable=%b addr=%h lat=%0d rdy=%b want res=ffffff80 stable addr=00002000 lat=5 rdy=0",
                  o.result, o.unstable, o.addr, o.latency, o.ready_at_wb);
      end
      run_op(mk_instr(OP_LOAD, 5'd7, F3_LBU), 32'h0000_2001, 32'h0, 1'b1, 1'b1, 1'b0,
             32'h0000_8000, 3, o);
      total++;
      if (o.timeout || o.result !== 32'h0000_0080) begin
         bad++;
         $display("FAIL load_lbu got res=%h to=%b want 00000080", o.result, o.timeout);
      end
   endtask

   task automatic test_misaligned();
      obs_t o;
      run_op(mk_instr(OP_LOAD, 5'd3, F3_LW), 32'h0000_3002, 32'h0, 1'b1, 1'b1, 1'b0,
             32'hDEAD_BEEF, 0, o);
      total++;
      if (o.timeout || o.saw_req || o.mis !== 1'b1 || o.rwe !== 1'b0 || o.latency !== 8'd1) begin
         bad++;
         $display("FAIL misaligned_lw got req=%b mis=%b rwe=%b lat=%0d want req=0 mis=1 rwe=0 lat=1",
                  o.saw_req, o.mis, o.rwe, o.latency);
      end
   endtask

   task automatic test_rd_zero();
      obs_t o;
      run_op(mk_instr(OP_LOAD, 5'd0, F3_LW), 32'h0000_4000, 32'h0, 1'b1, 1'b1, 1'b0,
             32'hCAFE_F00D, 0, o);
      total++;
      if (o.timeout || !o.saw_req || o.rwe !== 1'b0 || o.result !== 32'hCAFE_F00D ||
          o.latency !== 8'd2) begin
         bad++;
         $display("FAIL lw_rd0 got req=%b rwe=%b res=%h lat=%0d want req=1 rwe=0 res=cafef00d lat=2",
                  o.saw_req, o.rwe, o.result, o.latency);
      end
   endtask

   task automatic test_reset_mid_access();
      obs_t o;
      @(negedge clk);
      ex_valid = 1'b1; ex_instruction = mk_instr(OP_LOAD, 5'd4, F3_LW);
      ex_alu_result = 32'h0000_4000; ex_reg_write_enable = 1'b1; ex_mem_read = 1'b1;
      dmem_ready = 1'b0;
      @(negedge clk);
      ex_valid = 1'b0; ex_mem_read = 1'b0;
      total++;
      if (dmem_req !== 1'b1) begin
         bad++;
         $display("FAIL rst_mid_req_before got req=%b want 1", dmem_req);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++;
      if (dmem_req !== 1'b0 || wb_valid !== 1'b0 || ex_ready !== 1'b1) begin
         bad++;
         $display("FAIL rst_mid_access got req=%b valid=%b ready=%b want 0 0 1",
                  dmem_req, wb_valid, ex_ready);
      end
      run_op(mk_instr(OP_ALU, 5'd12, 3'b000), 32'h0BAD_CAFE, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 0, o);
      total++;
      if (o.timeout || o.result !== 32'h0BAD_CAFE || o.rwe !== 1'b1 || o.latency !== 8'd1) begin
         bad++;
         $display("FAIL rst_mid_recover got res=%h rwe=%b lat=%0d want 0badcafe 1 1",
                  o.result, o.rwe, o.latency);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_q[$];
      logic [31:0] v;
      for (int k = 0; k <= 8; k++) begin
         @(negedge clk);
         if (k > 0) begin
            total++;
            if (wb_valid !== 1'b1 || wb_result !== exp_q[0] || ex_ready !== 1'b1) begin
               bad++;
               $display("FAIL b2b_%0d got valid=%b res=%h ready=%b want valid=1 res=%h ready=1",
                        k, wb_valid, wb_result, ex_ready, exp_q[0]);
            end
            void'(exp_q.pop_front());
         end
         if (k < 8) begin
            v = $urandom;
            ex_valid = 1'b1; ex_instruction = mk_instr(OP_ALU, 5'(k + 1), 3'b000);
            ex_alu_result = v; ex_reg_write_enable = 1'b1;
            ex_mem_read = 1'b0; ex_mem_write = 1'b0;
            exp_q.push_back(v);
         end else begin
            ex_valid = 1'b0;
         end
      end
      @(negedge clk);
      total++;
      if (wb_valid !== 1'b0) begin
         bad++;
         $display("FAIL b2b_idle got valid=%b want 0", wb_valid);
      end
   endtask

   task automatic test_random();
      obs_t o;
      int kind;
      int waits;
      int n;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [31:0] alu, rs2, rdata, instr, e_res;
      logic        rwe, mr, mw, e_mis, e_req, e_rwe;
      for (int i = 0; i < 60; i++) begin
         kind  = $urandom_range(0, 2);
         rd    = 5'($urandom_range(0, 31));
         rwe   = ($urandom_range(0, 3) != 0);
         alu   = $urandom;
         rs2   = $urandom;
         rdata = $urandom;
         waits = $urandom_range(0, 3);
         mr    = (kind == 1);
         mw    = (kind == 2);
         f3    = mw ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) alu[1:0] = 2'b00;
         instr = mk_instr(mr ? OP_LOAD : (mw ? OP_STORE : OP_ALU), rd, f3);
         n      = acc_bytes(f3);
         e_mis  = (mr || mw) && ((int'(alu[1:0]) % n) != 0);
         e_req  = (mr || mw) && !e_mis;
         e_res  = (mr && !e_mis) ? model_load(f3, alu[1:0], rdata) : alu;
         e_rwe  = rwe && (rd != 5'd0) && !mw && !e_mis;
         run_op(instr, alu, rs2, rwe, mr, mw, rdata, waits, o);
         total++;
         if (o.timeout || o.instr !== instr || o.result !== e_res || o.rwe !== e_rwe ||
             o.mis !== e_mis || o.valid_after !== 1'b0) begin
            bad++;
            $display("FAIL rnd_wb op=%0d kind=%0d f3=%0d alu=%h got res=%h rwe=%b mis=%b to=%b want res=%h rwe=%b mis=%b",
                     i, kind, f3, alu, o.result, o.rwe, o.mis, o.timeout, e_res, e_rwe, e_mis);
         end
         total++;
         if (o.saw_req !== e_req || o.latency !== 8'(e_req ? waits + 2 : 1) || o.unstable) begin
            bad++;
            $display("FAIL rnd_timing op=%0d got req=%b lat=%0d unstable=%b want req=%b lat=%0d",
                     i, o.saw_req, o.latency, o.unstable, e_req, e_req ? waits + 2 : 1);
         end
         if (e_req) begin
            total++;
            if (o.addr !== {alu[31:2], 2'b00} || o.we !== mw ||
                o.wstrb !== (mw ? model_strb(f3, alu[1:0]) : 4'b0000) ||
                (mw && o.wdata !== model_wdata(f3, rs2))) begin
               bad++;
               $display("FAIL rnd_dmem op=%0d got addr=%h we=%b strb=%b wdata=%h want addr=%h we=%b strb=%b wdata=%h",
                        i, o.addr, o.we, o.wstrb, o.wdata, {alu[31:2], 2'b00}, mw,
                        mw ? model_strb(f3, alu[1:0]) : 4'b0000, model_wdata(f3, rs2));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_store_sb();
      test_load_wait();
      test_misaligned();
      test_rd_zero();
      test_reset_mid_access();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
